// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a program image as a byte stream, writes it word by word into the
// instruction memory and keeps the processor in reset until the image is in.
//
// Frame: count byte N (1..2^ADDR_W), then N*4 data bytes (MSB first), then
// an XOR checksum byte when the LOADER_CHECKSUM_EN macro is defined. The
// checksum covers the count byte and every data byte.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   start      single-cycle pulse: abort any load, wait for a new count byte
//   in_data    stream byte
//   in_valid   stream byte valid
//   in_ready   loader can take a byte this cycle (combinational)
//   mem_we     instruction memory write strobe (one cycle per word)
//   mem_addr   instruction memory word address
//   mem_wdata  instruction memory write data
//   cpu_rst    active-low processor reset (0 = core held)
//   done       image loaded, core released
//   error      frame rejected (bad count or bad checksum)
//
// Build option: LOADER_CHECKSUM_EN adds the trailing checksum byte check.
module imem_boot_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam int          CNT_W     = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_COUNT = 3'd0,
        ST_DATA  = 3'd1,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK   = 3'd2,
`endif
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    state_e              state_q,   state_d;
    logic                mem_we_q,  mem_we_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q,    done_d;
    logic                error_q,   error_d;
    logic [1:0]          idx_q,     idx_d;
    logic [CNT_W-1:0]    words_q,   words_d;
    // holds the first three bytes of the word being assembled
    logic [DATA_W-9:0]   asm_q,     asm_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_q,     chk_d;
`endif

    logic accept_s;
    logic count_ok_s;

    assign in_ready = ((state_q == ST_COUNT) || (state_q == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
                       || (state_q == ST_CHK)
`endif
                      ) && !start;

    assign accept_s   = in_valid && in_ready;
    assign count_ok_s = (in_data != 8'd0) && (32'(in_data) <= MAX_WORDS);

    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign error     = error_q;

    // Next-state and next-output computation for the frame receiver.
    always_comb begin
        state_d   = state_q;
        mem_we_d  = 1'b0;
        // the address advances in the cycle after each write strobe
        addr_d    = mem_we_q ? (addr_q + ADDR_W'(1)) : addr_q;
        wdata_d   = wdata_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        error_d   = error_q;
        idx_d     = idx_q;
        words_d   = words_q;
        asm_d     = asm_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        if (start) begin
            state_d   = ST_COUNT;
            addr_d    = {ADDR_W{1'b0}};
            idx_d     = 2'd0;
            done_d    = 1'b0;
            error_d   = 1'b0;
            cpu_rst_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_d     = 8'd0;
`endif
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (accept_s && count_ok_s) begin
                        words_d = CNT_W'(in_data);
                        idx_d   = 2'd0;
                        state_d = ST_DATA;
`ifdef LOADER_CHECKSUM_EN
                        chk_d   = in_data;
`endif
                    end else if (accept_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        asm_d = {asm_q[DATA_W-17:0], in_data};
                        idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_d = chk_q ^ in_data;
`endif
                        if (idx_q == 2'd3) begin
                            mem_we_d = 1'b1;
                            wdata_d  = {asm_q, in_data};
                            words_d  = words_q - CNT_W'(1);
                            if (words_q == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                                state_d = ST_CHK;
`else
                                // done rises one cycle later, after the strobe
                                state_d = ST_DONE;
`endif
                            end else begin
                                state_d = ST_DATA;
                            end
                        end else begin
                            mem_we_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept_s) begin
                        state_d = (in_data == chk_q) ? ST_DONE : ST_ERROR;
                    end else begin
                        state_d = ST_CHK;
                    end
                end
`endif
                ST_DONE: begin
                    done_d    = 1'b1;
                    cpu_rst_d = 1'b1;
                    error_d   = 1'b0;
                end
                ST_ERROR: begin
                    error_d   = 1'b1;
                    cpu_rst_d = 1'b0;
                    done_d    = 1'b0;
                end
                default: begin
                    state_d = ST_COUNT;
                end
            endcase
        end
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_COUNT;
            mem_we_q  <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            idx_q     <= 2'd0;
            words_q   <= {CNT_W{1'b0}};
            asm_q     <= {(DATA_W-8){1'b0}};
`ifdef LOADER_CHECKSUM_EN
            chk_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            error_q   <= error_d;
            idx_q     <= idx_d;
            words_q   <= words_d;
            asm_q     <= asm_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule
